// File: rtl/mlp_layer_sequencer_if.sv
// Handshake/bus bundle between the MLP layer sequencer and its DRAM, GLB, PE-array and PPU neighbours.
// The master modport is the sequencer side and the slave modport is the datapath/environment side.
interface mlp_layer_sequencer_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              start;
    logic [7:0]        in_dim;
    logic [7:0]        out_dim;
    logic              ready;
    logic              ifmap_wen;
    logic              weight_wen;
    logic              bias_wen;
    logic [ADDR_W-1:0] data_address;
    logic              array_en;
    logic              psum_sel;
    logic              array_valid;
    logic              ofmap_wen;
    logic [ADDR_W-1:0] ofmap_addr;
    logic              ppu_en;
    logic              ppu_valid;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       perf_stall;

    modport master (
        input  start, in_dim, out_dim, ready, array_valid, ppu_valid,
        output ifmap_wen, weight_wen, bias_wen, data_address, array_en, psum_sel,
               ofmap_wen, ofmap_addr, ppu_en, busy, done, err, perf_stall
    );

    modport slave (
        output start, in_dim, out_dim, ready, array_valid, ppu_valid,
        input  ifmap_wen, weight_wen, bias_wen, data_address, array_en, psum_sel,
               ofmap_wen, ofmap_addr, ppu_en, busy, done, err, perf_stall
    );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Runtime-configurable layer sequencer for the int8 MLP accelerator: DRAM->GLB loads, PE-array tiling,
// ofmap tile write-back and PPU drain. Define PERF_CNT_EN to build the array-wait stall counter on perf_stall.
module mlp_layer_sequencer #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ARR_ROWS = 8,
    parameter int unsigned ARR_COLS = 8,
    parameter int unsigned MAX_DIM  = 64,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    mlp_layer_sequencer_if.master bus
);

    localparam logic [7:0] PACK = 8'(DATA_W / 8);
    localparam logic [7:0] COLS = 8'(ARR_COLS);
    localparam logic [7:0] ROWS = 8'(ARR_ROWS);
    localparam logic [8:0] MAXD = 9'(MAX_DIM);

    typedef enum logic [3:0] {
        IDLE,
        LD_IFMAP,
        LD_WEIGHT,
        LD_BIAS,
        ISSUE,
        WAIT,
        WR_TILE,
        DRAIN,
        FIN
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [7:0]        in_dim_q;
    logic [7:0]        out_dim_q;
    logic [7:0]        k_idx;
    logic [7:0]        o_idx;
    logic [7:0]        k_tiles;
    logic [7:0]        o_tiles;
    logic [7:0]        issue_cnt;
    logic [7:0]        rcv_cnt;
    logic [7:0]        rcv_nx;
    logic [ADDR_W-1:0] ld_cnt;
    logic [15:0]       ld_words;
    logic [15:0]       tile_addr;
    logic              cfg_ok;
    logic              ld_state;
    logic              ld_done;
    logic              k_last;
    logic              o_last;
    logic              err_q;

    assign cfg_ok = (bus.in_dim != '0) && (bus.out_dim != '0)
                 && ((bus.in_dim % COLS) == '0) && ((bus.out_dim % ROWS) == '0)
                 && ({1'b0, bus.in_dim} <= MAXD) && ({1'b0, bus.out_dim} <= MAXD);

    assign k_tiles   = in_dim_q / COLS;
    assign o_tiles   = out_dim_q / ROWS;
    assign k_last    = (k_idx == k_tiles - 8'd1);
    assign o_last    = (o_idx == o_tiles - 8'd1);
    assign tile_addr = 16'(o_idx) * 16'(k_tiles) + 16'(k_idx);
    assign ld_state  = (state == LD_IFMAP) || (state == LD_WEIGHT) || (state == LD_BIAS);
    assign ld_done   = (16'(ld_cnt) == ld_words - 16'd1);

    // Receive counter saturates at out_dim so stray ppu_valid pulses cannot overrun it.
    assign rcv_nx = (bus.ppu_valid && (rcv_cnt != out_dim_q)) ? rcv_cnt + 8'd1 : rcv_cnt;

    always_comb begin
        ld_words = 16'd1;
        case (state)
            LD_IFMAP:  ld_words = 16'(in_dim_q / PACK);
            LD_WEIGHT: ld_words = (16'(in_dim_q) * 16'(out_dim_q)) / 16'(PACK);
            LD_BIAS:   ld_words = 16'(out_dim_q);
            default:   ld_words = 16'd1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = cfg_ok ? LD_IFMAP : FIN;
                end
            end
            LD_IFMAP:  if (bus.ready && ld_done) state_nx = LD_WEIGHT;
            LD_WEIGHT: if (bus.ready && ld_done) state_nx = LD_BIAS;
            LD_BIAS:   if (bus.ready && ld_done) state_nx = ISSUE;
            ISSUE:     state_nx = WAIT;
            WAIT: begin
                if (bus.array_valid) begin
                    state_nx = k_last ? WR_TILE : ISSUE;
                end
            end
            WR_TILE:   state_nx = o_last ? DRAIN : ISSUE;
            DRAIN:     if (rcv_nx == out_dim_q) state_nx = FIN;
            FIN:       state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_dim_q  <= '0;
            out_dim_q <= '0;
            err_q     <= 1'b0;
            ld_cnt    <= '0;
            k_idx     <= '0;
            o_idx     <= '0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        in_dim_q  <= bus.in_dim;
                        out_dim_q <= bus.out_dim;
                        err_q     <= !cfg_ok;
                    end
                end
                LD_IFMAP, LD_WEIGHT, LD_BIAS: begin
                    if (bus.ready) begin
                        ld_cnt <= ld_done ? '0 : ld_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.array_valid && !k_last) begin
                        k_idx <= k_idx + 8'd1;
                    end
                end
                WR_TILE: begin
                    k_idx <= '0;
                    o_idx <= o_last ? '0 : o_idx + 8'd1;
                end
                DRAIN: begin
                    if (issue_cnt != out_dim_q) begin
                        issue_cnt <= issue_cnt + 8'd1;
                    end
                    rcv_cnt <= rcv_nx;
                end
                FIN: begin
                    issue_cnt <= '0;
                    rcv_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

    // A single GLB address port: ISSUE/WAIT present the weight/bias tile base o*k_tiles+k.
    always_comb begin
        bus.ifmap_wen    = 1'b0;
        bus.weight_wen   = 1'b0;
        bus.bias_wen     = 1'b0;
        bus.data_address = '0;
        bus.array_en     = 1'b0;
        bus.psum_sel     = 1'b0;
        bus.ofmap_wen    = 1'b0;
        bus.ofmap_addr   = '0;
        bus.ppu_en       = 1'b0;
        bus.busy         = (state != IDLE) && (state != FIN);
        bus.done         = (state == FIN);
        bus.err          = err_q;
        if (ld_state) begin
            bus.data_address = ld_cnt;
        end
        case (state)
            LD_IFMAP:  bus.ifmap_wen  = bus.ready;
            LD_WEIGHT: bus.weight_wen = bus.ready;
            LD_BIAS:   bus.bias_wen   = bus.ready;
            ISSUE: begin
                bus.array_en     = 1'b1;
                bus.psum_sel     = (k_idx != '0);
                bus.data_address = ADDR_W'(tile_addr);
            end
            WAIT: begin
                bus.psum_sel     = (k_idx != '0);
                bus.data_address = ADDR_W'(tile_addr);
            end
            WR_TILE: begin
                bus.ofmap_wen  = 1'b1;
                bus.ofmap_addr = ADDR_W'(o_idx);
            end
            DRAIN: begin
                if (issue_cnt != out_dim_q) begin
                    bus.ppu_en     = 1'b1;
                    bus.ofmap_addr = ADDR_W'(issue_cnt);
                end
            end
            default: ;
        endcase
    end

`ifdef PERF_CNT_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state == IDLE) && bus.start) begin
            perf_q <= '0;
        end else if ((state == WAIT) && !bus.array_valid && (perf_q != '1)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign bus.perf_stall = perf_q;
`else
    assign bus.perf_stall = '0;
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench for mlp_layer_sequencer: randomized DRAM/array/PPU responders and a transaction-level
// reference model of the expected load, tiling, write-back and drain sequences.
module tb_mlp_layer_sequencer;
    localparam int unsigned ADDR_W = 12;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mlp_layer_sequencer_if #(.ADDR_W(ADDR_W)) ifc ();

    mlp_layer_sequencer #(
        .DATA_W(32), .ARR_ROWS(8), .ARR_COLS(8), .MAX_DIM(64), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    int checks = 0;
    int errors = 0;
    int q_if[$], q_wt[$], q_bs[$], q_ps[$], q_aa[$], q_ofw[$], q_ppu[$];
    int done_cnt, done_err, done_busy, done_perf, done_delivered;
    int hold_bad, exp_wt, ready_mode, stall_cycles;
    int arr_timer, ppu_pending, ppu_delivered;
    bit ppu_rand, tog;

    function automatic logic [49:0] outs();
        return {ifc.ifmap_wen, ifc.weight_wen, ifc.bias_wen, ifc.data_address, ifc.array_en,
                ifc.psum_sel, ifc.ofmap_wen, ifc.ofmap_addr, ifc.ppu_en, ifc.busy, ifc.done,
                ifc.err, ifc.perf_stall};
    endfunction

    task automatic clear_env();
        q_if.delete(); q_wt.delete(); q_bs.delete(); q_ps.delete();
        q_aa.delete(); q_ofw.delete(); q_ppu.delete();
        done_cnt = 0; done_err = 0; done_busy = 0; done_perf = 0; done_delivered = 0;
        hold_bad = 0; ppu_delivered = 0;
    endtask

    // Monitor: samples DUT outputs mid-cycle and records transactions.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifc.ifmap_wen)  q_if.push_back(int'(ifc.data_address));
                if (ifc.weight_wen) q_wt.push_back(int'(ifc.data_address));
                if (ifc.bias_wen)   q_bs.push_back(int'(ifc.data_address));
                if (!ifc.ready && (ifc.ifmap_wen || ifc.weight_wen || ifc.bias_wen)) hold_bad++;
                if (!ifc.ready && q_wt.size() > 0 && q_wt.size() < exp_wt
                    && int'(ifc.data_address) != q_wt.size()) hold_bad++;
                if (ifc.array_en) begin
                    q_ps.push_back(int'(ifc.psum_sel));
                    q_aa.push_back(int'(ifc.data_address));
                    arr_timer = stall_cycles + 1;
                end
                if (ifc.ofmap_wen) q_ofw.push_back(int'(ifc.ofmap_addr));
                if (ifc.ppu_en) begin
                    q_ppu.push_back(int'(ifc.ofmap_addr));
                    ppu_pending++;
                end
                if (ifc.done) begin
                    done_cnt++;
                    done_err = int'(ifc.err);
                    done_busy = int'(ifc.busy);
                    done_perf = int'(ifc.perf_stall);
                    done_delivered = ppu_delivered;
                end
            end
        end
    end

    // Environment: DRAM ready, array result after stall_cycles WAIT cycles, PPU returns one word per ppu_en.
    initial begin
        ifc.ready = 1'b0; ifc.array_valid = 1'b0; ifc.ppu_valid = 1'b0;
        arr_timer = 0; ppu_pending = 0; tog = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                ifc.ready = 1'b0; ifc.array_valid = 1'b0; ifc.ppu_valid = 1'b0;
                arr_timer = 0; ppu_pending = 0;
            end else begin
                case (ready_mode)
                    0: ifc.ready = 1'b1;
                    1: begin tog = !tog; ifc.ready = tog; end
                    default: ifc.ready = 1'($urandom_range(0, 1));
                endcase
                ifc.array_valid = 1'b0;
                if (arr_timer > 0) begin
                    arr_timer--;
                    if (arr_timer == 0) ifc.array_valid = 1'b1;
                end
                ifc.ppu_valid = 1'b0;
                if (ppu_pending > 0 && (!ppu_rand || $urandom_range(0, 2) != 0)) begin
                    ifc.ppu_valid = 1'b1;
                    ppu_pending--;
                    ppu_delivered++;
                end
            end
        end
    end

    task automatic test_layer(input int in_d, input int out_d, input int mode, input int stall, input bit poke);
        int cyc, bad, kt, ot, exp_perf, held_perf;
        kt = in_d / 8;
        ot = out_d / 8;
        clear_env();
        ready_mode = mode; stall_cycles = stall; exp_wt = in_d * out_d / 4;
`ifdef PERF_CNT_EN
        exp_perf = kt * ot * stall;
        if (exp_perf > 65535) exp_perf = 65535;
`else
        exp_perf = 0;
`endif
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.in_dim = 8'(in_d); ifc.out_dim = 8'(out_d);
        @(posedge clk); #1;
        ifc.start = 1'b0; ifc.in_dim = 8'($urandom); ifc.out_dim = 8'($urandom);
        @(negedge clk);
        checks++;
        if (ifc.busy !== 1'b1 || ifc.err !== 1'b0 || ifc.perf_stall !== 16'd0) begin
            errors++;
            $display("FAIL start_state %0dx%0d: busy=%b err=%b perf=%0d required busy=1 err=0 perf=0",
                     in_d, out_d, ifc.busy, ifc.err, ifc.perf_stall);
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 3) begin
                ifc.start = 1'b1; ifc.in_dim = 8'd24; ifc.out_dim = 8'd24;
            end else begin
                ifc.start = 1'b0;
            end
        end
        ifc.start = 1'b0;
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout %0dx%0d: no done within %0d cycles", in_d, out_d, LIMIT);
        end
        held_perf = done_perf;
        repeat (3) @(negedge clk);

        bad = 0;
        foreach (q_if[i]) if (q_if[i] != i) bad++;
        checks++;
        if (q_if.size() != in_d / 4 || bad != 0) begin
            errors++;
            $display("FAIL ifmap_load %0dx%0d: count=%0d bad_addr=%0d required count=%0d", in_d, out_d, q_if.size(), bad, in_d / 4);
        end
        bad = 0;
        foreach (q_wt[i]) if (q_wt[i] != i) bad++;
        checks++;
        if (q_wt.size() != exp_wt || bad != 0 || hold_bad != 0) begin
            errors++;
            $display("FAIL weight_load %0dx%0d: count=%0d bad_addr=%0d hold_bad=%0d required count=%0d bad=0",
                     in_d, out_d, q_wt.size(), bad, hold_bad, exp_wt);
        end
        bad = 0;
        foreach (q_bs[i]) if (q_bs[i] != i) bad++;
        checks++;
        if (q_bs.size() != out_d || bad != 0) begin
            errors++;
            $display("FAIL bias_load %0dx%0d: count=%0d bad_addr=%0d required count=%0d", in_d, out_d, q_bs.size(), bad, out_d);
        end
        bad = 0;
        foreach (q_ps[i]) begin
            if (q_ps[i] != ((i % kt) != 0 ? 1 : 0)) bad++;
            if (q_aa[i] != (i / kt) * kt + (i % kt)) bad++;
        end
        checks++;
        if (q_ps.size() != kt * ot || bad != 0) begin
            errors++;
            $display("FAIL array_passes %0dx%0d: passes=%0d bad_psum_or_addr=%0d required passes=%0d",
                     in_d, out_d, q_ps.size(), bad, kt * ot);
        end
        bad = 0;
        foreach (q_ofw[i]) if (q_ofw[i] != i) bad++;
        checks++;
        if (q_ofw.size() != ot || bad != 0) begin
            errors++;
            $display("FAIL ofmap_write %0dx%0d: tiles=%0d bad_addr=%0d required tiles=%0d", in_d, out_d, q_ofw.size(), bad, ot);
        end
        bad = 0;
        foreach (q_ppu[i]) if (q_ppu[i] != i) bad++;
        checks++;
        if (q_ppu.size() != out_d || bad != 0 || done_delivered != out_d) begin
            errors++;
            $display("FAIL ppu_drain %0dx%0d: ppu_en=%0d bad_addr=%0d valid_before_done=%0d required %0d",
                     in_d, out_d, q_ppu.size(), bad, done_delivered, out_d);
        end
        checks++;
        if (done_cnt != 1 || done_err != 0 || done_busy != 0) begin
            errors++;
            $display("FAIL done_pulse %0dx%0d: pulses=%0d err=%0d busy=%0d required 1,0,0", in_d, out_d, done_cnt, done_err, done_busy);
        end
        checks++;
        if (held_perf != exp_perf || int'(ifc.perf_stall) != exp_perf) begin
            errors++;
            $display("FAIL perf_stall %0dx%0d: at_done=%0d later=%0d required %0d", in_d, out_d, held_perf, ifc.perf_stall, exp_perf);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", outs());
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_illegal();
        int cfg_in[5]  = '{12, 8, 72, 8, 0};
        int cfg_out[5] = '{8, 0, 8, 12, 8};
        for (int i = 0; i < 5; i++) begin
            clear_env();
            ready_mode = 0;
            @(posedge clk); #1;
            ifc.start = 1'b1; ifc.in_dim = 8'(cfg_in[i]); ifc.out_dim = 8'(cfg_out[i]);
            @(posedge clk); #1;
            ifc.start = 1'b0;
            @(negedge clk);
            checks++;
            if (ifc.done !== 1'b1 || ifc.err !== 1'b1 || ifc.busy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_reject %0dx%0d: done=%b err=%b busy=%b required 1,1,0",
                         cfg_in[i], cfg_out[i], ifc.done, ifc.err, ifc.busy);
            end
            repeat (8) @(negedge clk);
            checks++;
            if (ifc.err !== 1'b1 || done_cnt != 1 || q_if.size() + q_wt.size() + q_bs.size() + q_ps.size() != 0) begin
                errors++;
                $display("FAIL illegal_quiet %0dx%0d: err=%b done_pulses=%0d wen=%0d required err=1 pulses=1 wen=0",
                         cfg_in[i], cfg_out[i], ifc.err, done_cnt, q_if.size() + q_wt.size() + q_bs.size());
            end
        end
        test_layer(8, 8, 0, 0, 1'b0);
    endtask

    task automatic test_reset_midrun();
        int cyc;
        clear_env();
        ready_mode = 0; stall_cycles = 60; exp_wt = 64;
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.in_dim = 8'd16; ifc.out_dim = 8'd16;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        cyc = 0;
        while (q_ps.size() < 2 && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (q_ps.size() != 2) begin
            errors++;
            $display("FAIL reach_second_tile: array_en=%0d required 2", q_ps.size());
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h required 0", outs());
        end
        clear_env();
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.in_dim = 8'd8; ifc.out_dim = 8'd8;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (ifc.busy !== 1'b0 || q_if.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL start_with_reset: busy=%b ifmap_wen=%0d done=%0d required 0,0,0", ifc.busy, q_if.size(), done_cnt);
        end
        test_layer(16, 16, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            ppu_rand = 1'b1;
            test_layer(8 * $urandom_range(1, 4), 8 * $urandom_range(1, 4), 2, $urandom_range(0, 4), 1'b1);
        end
        ppu_rand = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ifc.start = 1'b0; ifc.in_dim = '0; ifc.out_dim = '0;
        ready_mode = 0; stall_cycles = 0; exp_wt = 0; ppu_rand = 1'b0;
        clear_env();
        test_reset();
        test_layer(8, 8, 0, 0, 1'b0);
        test_layer(16, 16, 0, 1, 1'b0);
        test_layer(8, 8, 1, 0, 1'b0);
        test_illegal();
        test_reset_midrun();
        test_layer(8, 8, 0, 5, 1'b0);
        test_layer(64, 8, 0, 0, 1'b0);
        test_layer(8, 64, 0, 0, 1'b0);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
Parametrised next-generation layer sequencer for the int8 MLP accelerator. It replaces the fixed two-mode controller with a runtime-configurable in_dim/out_dim engine.
- Streams ifmap, weight and bias words from DRAM into the GLB SRAMs.
- Tiles the layer over the PE array and selects bias or accumulated partial sum per tile.
- Writes finished ofmap tiles, then drains them through the PPU.
- Sits between the DRAM stream interface and the GLB/PE_array/PPU datapath.

Parameters:
DATA_W, 32, DRAM word width (4 packed int8 per word)
ARR_ROWS, 8, output channels produced per array pass
ARR_COLS, 8, input channels consumed per array pass
MAX_DIM, 64, largest legal in_dim/out_dim
ADDR_W, 12, GLB address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle layer start; sampled only in IDLE
in_dim  in  8  input channels; sampled at start
out_dim  in  8  output channels; sampled at start
ready  in  1  DRAM word valid on data_in this cycle
ifmap_wen  out  1  GLB ifmap write enable
weight_wen  out  1  GLB weight write enable
bias_wen  out  1  GLB bias write enable
data_address  out  ADDR_W  GLB load/read address
array_en  out  1  one-cycle pulse launching one array pass
psum_sel  out  1  0 = bias feeds array accumulator, 1 = previous ofmap feeds it
array_valid  in  1  array pass result ready
ofmap_wen  out  1  GLB ofmap tile write
ofmap_addr  out  ADDR_W  ofmap tile/word address
ppu_en  out  1  issue one ofmap word to PPU
ppu_valid  in  1  PPU output word valid
busy  out  1  high outside IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky illegal-config flag; cleared by next accepted start
perf_stall  out  16  array-wait cycle count (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; counters 0.
- Legality at start: in_dim, out_dim nonzero, multiples of ARR_COLS/ARR_ROWS respectively, and <= MAX_DIM.
  - Illegal config: next cycle err=1, done=1, back to IDLE; no GLB writes.
- States: IDLE -> LD_IFMAP -> LD_WEIGHT -> LD_BIAS -> ISSUE -> WAIT -> (ISSUE | WR_TILE) -> DRAIN -> FIN -> IDLE.
- Load states:
  - Word counts: LD_IFMAP = in_dim/4; LD_WEIGHT = in_dim*out_dim/4; LD_BIAS = out_dim.
  - The state's wen = ready (combinational); data_address = word counter, which advances only on ready.
  - ready low stalls with address held. Last word written -> counter clears, next state the following cycle.
- Compute tiling: outer o = 0..out_dim/ARR_ROWS-1, inner k = 0..in_dim/ARR_COLS-1.
  - ISSUE: array_en=1 for exactly one cycle; psum_sel=(k!=0); data_address = k for ifmap, o*(in_dim/ARR_COLS)+k for weight/bias base. Then -> WAIT.
  - WAIT: hold psum_sel until array_valid.
    - k not last: k++ and -> ISSUE.
    - k last: -> WR_TILE.
  - WR_TILE: ofmap_wen=1 one cycle, ofmap_addr=o. Then k=0; o++ -> ISSUE, or -> DRAIN after last o.
- array_valid outside WAIT: ignored.
- DRAIN: ppu_en=1 for out_dim consecutive cycles, ofmap_addr=0..out_dim-1. Separately count ppu_valid; when received == out_dim -> FIN.
- FIN: done=1 one cycle -> IDLE; busy falls the same cycle done is high.
- start while busy: ignored. start and rst together: reset wins.
- ppu_valid beyond out_dim: ignored, counter saturates.

Optional Feature:
PERF_CNT_EN:
- Defined: perf_stall counts cycles spent in WAIT with array_valid low. Clears on accepted start, saturates at 16'hFFFF, and holds after done.
- Undefined: perf_stall tied to 0 and no counter logic is generated.

Test Plan:
- in_dim=8, out_dim=8, ready held high -> exactly 2 ifmap_wen, 16 weight_wen, 8 bias_wen; 1 array_en with psum_sel=0; 1 ofmap_wen with ofmap_addr=0; 8 ppu_en; done after 8th ppu_valid; err=0.
- in_dim=16, out_dim=16 -> 4 array_en pulses with psum_sel sequence 0,1,0,1; ofmap_wen at ofmap_addr 0 then 1; 16 ppu_en.
- ready toggling 1,0,1,0 during LD_WEIGHT -> data_address holds on ready=0 cycles; weight_wen count still 16 (in_dim=8, out_dim=8).
- in_dim=12 -> err=1 and done=1 one cycle after start; zero wen pulses; next legal start clears err.
- Assert rst during WAIT in the second k tile -> all outputs 0 immediately (async); busy=0; a fresh start completes normally.
- With PERF_CNT_EN defined, array_valid delayed 5 cycles after each array_en (in_dim=8, out_dim=8) -> perf_stall=5 at done; with the macro undefined -> perf_stall=0.
